// File: rtl/uart_tx_sched_pkg.sv
// uart_tx_sched_pkg: FSM states, header tag and helpers for uart_tx_scheduler.
// Header framing is compiled in only when UART_TX_SCHED_HDR_EN is defined.
package uart_tx_sched_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_BUSY,
    S_WAIT_DONE,
    S_GAP
  } state_e;

  localparam logic [3:0] HDR_TAG = 4'hA;

  // Wide enough for any practical GAP_CYCLES / BUSY_TIMEOUT.
  localparam int CNT_W = 16;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_tx_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first request at or above ptr.
// The pointer register is owned by the parent.
module rr_arbiter
  import uart_tx_sched_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] id_o,
  output logic          any_o
);

  logic [IW:0]   sum;
  logic [IW-1:0] idx;

  // Walk upward from ptr with wrap; first hit wins.
  always_comb begin
    gnt_o = '0;
    id_o  = '0;
    any_o = 1'b0;
    sum   = '0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      sum = {1'b0, ptr_i} + (IW+1)'(k);
      if (sum >= (IW+1)'(N)) sum = sum - (IW+1)'(N);
      idx = sum[IW-1:0];
      if (!any_o && req_i[idx]) begin
        any_o      = 1'b1;
        gnt_o[idx] = 1'b1;
        id_o       = idx;
      end
    end
  end

endmodule

// File: rtl/uart_tx_scheduler.sv
// uart_tx_scheduler: round-robin sharing of one UART TX among requesters.
// Define UART_TX_SCHED_HDR_EN to send a header frame before each data byte.
module uart_tx_scheduler
  import uart_tx_sched_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int GAP_CYCLES   = 0,
  parameter int BUSY_TIMEOUT = 4
) (
  input  logic                        CLK,
  input  logic                        RST_n,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [8*NUM_REQ-1:0]        req_data,
  input  logic [NUM_REQ-1:0]          cfg_par_en,
  input  logic [NUM_REQ-1:0]          cfg_par_typ,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic                        tx_busy,
  output logic [7:0]                  tx_p_data,
  output logic                        tx_par_en,
  output logic                        tx_par_typ,
  output logic                        tx_data_valid,
  output logic [clog2(NUM_REQ)-1:0]   grant_id,
  output logic                        active,
  output logic                        timeout_err
);

  localparam int IW = clog2(NUM_REQ);
  // WAIT_BUSY is entered one cycle after the strobe, hence the -2.
  localparam int BT_LAST  = (BUSY_TIMEOUT > 2) ? BUSY_TIMEOUT - 2 : 0;
  localparam int GAP_LAST = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [IW-1:0]    ptr_q;
  logic [IW-1:0]    ptr_d;
  logic [IW-1:0]    gid_q;
  logic [7:0]       pdata_q;
  logic             pen_q;
  logic             ptyp_q;
  logic             act_q;
  logic             terr_q;

  logic [NUM_REQ-1:0] gnt;
  logic [IW-1:0]      gnt_id;
  logic               gnt_any;
  logic               busy_to;
  logic               gap_done;

`ifdef UART_TX_SCHED_HDR_EN
  logic             hdr_q;
  logic [7:0]       data_q;
`endif

  rr_arbiter #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_arb (
    .req_i (req_valid),
    .ptr_i (ptr_q),
    .gnt_o (gnt),
    .id_o  (gnt_id),
    .any_o (gnt_any)
  );

  // Ready is offered only while idle and never while reset is held.
  assign req_ready = (state_q == S_IDLE && RST_n) ? gnt : '0;

  // Strobe is qualified by live tx_busy so it can never overlap Busy.
  assign tx_data_valid = (state_q == S_ISSUE) && !tx_busy;

  assign ptr_d    = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + IW'(1);
  assign busy_to  = (cnt_q >= CNT_W'(BT_LAST));
  assign gap_done = (cnt_q >= CNT_W'(GAP_LAST));

  assign tx_p_data   = pdata_q;
  assign tx_par_en   = pen_q;
  assign tx_par_typ  = ptyp_q;
  assign grant_id    = gid_q;
  assign active      = act_q;
  assign timeout_err = terr_q;

  // Scheduler FSM with latched frame fields and sticky timeout flag.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      gid_q   <= '0;
      pdata_q <= 8'h00;
      pen_q   <= 1'b0;
      ptyp_q  <= 1'b0;
      act_q   <= 1'b0;
      terr_q  <= 1'b0;
`ifdef UART_TX_SCHED_HDR_EN
      hdr_q   <= 1'b0;
      data_q  <= 8'h00;
`endif
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (gnt_any) begin
            gid_q   <= gnt_id;
            ptr_q   <= ptr_d;
            pen_q   <= cfg_par_en[gnt_id];
            ptyp_q  <= cfg_par_typ[gnt_id];
`ifdef UART_TX_SCHED_HDR_EN
            pdata_q <= {HDR_TAG, 4'(gnt_id)};
            data_q  <= req_data[8*gnt_id +: 8];
            hdr_q   <= 1'b1;
`else
            pdata_q <= req_data[8*gnt_id +: 8];
`endif
            act_q   <= 1'b1;
            state_q <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (!tx_busy) begin
            cnt_q   <= '0;
            state_q <= S_WAIT_BUSY;
          end
        end
        S_WAIT_BUSY: begin
          if (tx_busy) begin
            state_q <= S_WAIT_DONE;
          end else if (busy_to) begin
            terr_q  <= 1'b1;
            state_q <= S_ISSUE;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_WAIT_DONE: begin
          if (!tx_busy) begin
            cnt_q <= '0;
`ifdef UART_TX_SCHED_HDR_EN
            if (hdr_q) pdata_q <= data_q;
            if (GAP_CYCLES > 0) begin
              state_q <= S_GAP;
            end else if (hdr_q) begin
              hdr_q   <= 1'b0;
              state_q <= S_ISSUE;
            end else begin
              act_q   <= 1'b0;
              state_q <= S_IDLE;
            end
`else
            if (GAP_CYCLES > 0) begin
              state_q <= S_GAP;
            end else begin
              act_q   <= 1'b0;
              state_q <= S_IDLE;
            end
`endif
          end
        end
        S_GAP: begin
          if (gap_done) begin
`ifdef UART_TX_SCHED_HDR_EN
            if (hdr_q) begin
              hdr_q   <= 1'b0;
              state_q <= S_ISSUE;
            end else begin
              act_q   <= 1'b0;
              state_q <= S_IDLE;
            end
`else
            act_q   <= 1'b0;
            state_q <= S_IDLE;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// tb_uart_tx_scheduler: vector table plus scoreboarded sequences
// against a behavioural transmitter Busy model.
module tb_uart_tx_scheduler;

  localparam int N   = 4;
  localparam int GAP = 3;
  localparam int FL  = 5;
`ifdef UART_TX_SCHED_HDR_EN
  localparam bit HDR = 1'b1;
`else
  localparam bit HDR = 1'b0;
`endif

  typedef struct {
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic [1:0] id;
  } frame_t;

  typedef struct {
    int         r;
    logic [7:0] d;
    logic       pe;
    logic       pt;
    logic [3:0] rdy;
    logic [1:0] gid;
  } vec_t;

  logic           CLK = 1'b0;
  logic           RST_n = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   cfg_par_en = '0;
  logic [N-1:0]   cfg_par_typ = '0;
  logic [N-1:0]   req_ready;
  logic           tx_busy = 1'b0;
  logic [7:0]     tx_p_data;
  logic           tx_par_en;
  logic           tx_par_typ;
  logic           tx_data_valid;
  logic [1:0]     grant_id;
  logic           active;
  logic           timeout_err;

  int nvec = 0;
  int nerr = 0;

  frame_t sb_q[$];
  frame_t last_f;
  int     grants[$];
  vec_t   vt[5];

  int   ptr_m = 0;
  int   bcnt = 0;
  int   cyc_n = 0;
  int   fall_cyc = -1;
  int   acc_id = -1;
  logic [N-1:0] acc_vec = '0;
  logic strobe = 1'b0;
  logic prev_strobe = 1'b0;
  logic prev_busy = 1'b0;
  logic open = 1'b0;
  logic terr_s = 1'b0;
  logic hold_busy = 1'b0;
  logic no_busy = 1'b0;
  logic cont = 1'b0;
  logic gap_chk = 1'b0;

  uart_tx_scheduler #(
    .NUM_REQ      (N),
    .GAP_CYCLES   (GAP),
    .BUSY_TIMEOUT (4)
  ) dut (
    .CLK           (CLK),
    .RST_n         (RST_n),
    .req_valid     (req_valid),
    .req_data      (req_data),
    .cfg_par_en    (cfg_par_en),
    .cfg_par_typ   (cfg_par_typ),
    .req_ready     (req_ready),
    .tx_busy       (tx_busy),
    .tx_p_data     (tx_p_data),
    .tx_par_en     (tx_par_en),
    .tx_par_typ    (tx_par_typ),
    .tx_data_valid (tx_data_valid),
    .grant_id      (grant_id),
    .active        (active),
    .timeout_err   (timeout_err)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h (cycle %0d)",
               nm, act, exp, cyc_n);
    end
  endtask

  task automatic tmo(input string nm, input int lim);
    nvec++;
    nerr++;
    $display("FAIL %s: no response within %0d cycles", nm, lim);
  endtask

  function automatic int pick(input logic [N-1:0] v, input int p);
    for (int k = 0; k < N; k++)
      if (v[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  // Sample the DUT mid-cycle and score against the reference model.
  task automatic mon();
    logic [N-1:0] rdy;
    int id;
    frame_t f;
    cyc_n++;
    acc_vec = '0;
    acc_id  = -1;
    strobe  = tx_data_valid;
    terr_s  = timeout_err;
    rdy     = req_ready;
    if (rdy != '0) begin
      id = pick(req_valid, ptr_m);
      chk("req_ready", rdy, (id < 0) ? 0 : (1 << id));
      if (id >= 0) begin
        if (gap_chk && fall_cyc >= 0)
          chk("gap_to_accept", cyc_n - fall_cyc, GAP + 1);
        ptr_m = (id + 1) % N;
        grants.push_back(id);
        acc_vec = rdy;
        acc_id  = id;
        f.id = 2'(id);
        f.pe = cfg_par_en[id];
        f.pt = cfg_par_typ[id];
        if (HDR) begin
          f.d = {4'hA, 2'b00, 2'(id)};
          sb_q.push_back(f);
        end
        f.d = req_data[8*id +: 8];
        sb_q.push_back(f);
      end
    end
    if (strobe) begin
      chk("busy_at_strobe", tx_busy, 0);
      chk("strobe_b2b", prev_strobe, 0);
      if (open) begin
        f = last_f;
      end else begin
        chk("sb_empty_at_strobe", sb_q.size() == 0, 0);
        if (sb_q.size() != 0) f = sb_q.pop_front();
        else f = last_f;
      end
      chk("tx_p_data", tx_p_data, f.d);
      chk("tx_par_en", tx_par_en, f.pe);
      chk("tx_par_typ", tx_par_typ, f.pt);
      chk("grant_id", grant_id, f.id);
      last_f = f;
      open = 1'b1;
    end
    if (prev_busy && !tx_busy) fall_cyc = cyc_n;
    if (tx_busy) open = 1'b0;
    prev_strobe = strobe;
    prev_busy   = tx_busy;
  endtask

  // Transmitter Busy model and requester reaction to accepts.
  task automatic drv();
    if (strobe && !no_busy) bcnt = FL;
    else if (bcnt > 0) bcnt--;
    tx_busy = hold_busy | (bcnt != 0);
    if (acc_id >= 0) begin
      if (cont) req_data[8*acc_id +: 8] = req_data[8*acc_id +: 8] + 8'h11;
      else req_valid[acc_id] = 1'b0;
    end
  endtask

  task automatic cyc();
    @(negedge CLK);
    mon();
    @(posedge CLK);
    #1;
    drv();
  endtask

  task automatic wait_acc(input string nm, input int lim, output int id);
    id = -1;
    for (int n = 0; n < lim; n++) begin
      cyc();
      if (acc_id >= 0) begin
        id = acc_id;
        break;
      end
    end
    if (id < 0) tmo(nm, lim);
  endtask

  task automatic drain(input string nm, input int lim);
    int n;
    n = 0;
    while (!(req_valid == '0 && active == 1'b0) && n < lim) begin
      cyc();
      n++;
    end
    if (n >= lim) tmo(nm, lim);
  endtask

  task automatic chk_reset(input string nm);
    chk({nm, "_req_ready"}, req_ready, 0);
    chk({nm, "_tx_data_valid"}, tx_data_valid, 0);
    chk({nm, "_active"}, active, 0);
    chk({nm, "_timeout_err"}, timeout_err, 0);
    chk({nm, "_tx_p_data"}, tx_p_data, 0);
    chk({nm, "_tx_par_en"}, tx_par_en, 0);
    chk({nm, "_tx_par_typ"}, tx_par_typ, 0);
    chk({nm, "_grant_id"}, grant_id, 0);
  endtask

  task automatic rst_model();
    sb_q.delete();
    grants.delete();
    ptr_m = 0;
    bcnt = 0;
    tx_busy = 1'b0;
    open = 1'b0;
    hold_busy = 1'b0;
    no_busy = 1'b0;
    prev_busy = 1'b0;
    prev_strobe = 1'b0;
    fall_cyc = -1;
  endtask

  initial begin
    int r;
    int id;
    int cnt;
    int t0;
    logic [3:0] seen;

    vt[0] = '{1, 8'h5A, 1'b1, 1'b0, 4'b0010, 2'd1};
    vt[1] = '{3, 8'hC3, 1'b1, 1'b1, 4'b1000, 2'd3};
    vt[2] = '{0, 8'h00, 1'b0, 1'b1, 4'b0001, 2'd0};
    vt[3] = '{2, 8'hFF, 1'b0, 1'b0, 4'b0100, 2'd2};
    vt[4] = '{3, 8'h81, 1'b0, 1'b0, 4'b1000, 2'd3};

    cyc();
    cyc();
    chk_reset("por");
    RST_n = 1'b1;
    cyc();

    // Single-requester vectors.
    foreach (vt[v]) begin
      r = vt[v].r;
      req_data[8*r +: 8] = vt[v].d;
      cfg_par_en[r]  = vt[v].pe;
      cfg_par_typ[r] = vt[v].pt;
      req_valid = '0;
      req_valid[r] = 1'b1;
      wait_acc("vec_accept", 20, id);
      chk("vec_ready", acc_vec, vt[v].rdy);
      cyc();
      chk("vec_strobe_next", strobe, 1);
      chk("vec_grant_id", grant_id, vt[v].gid);
      chk("vec_par_en", tx_par_en, vt[v].pe);
      chk("vec_par_typ", tx_par_typ, vt[v].pt);
      chk("vec_p_data", tx_p_data,
          HDR ? {4'hA, 2'b00, vt[v].gid} : vt[v].d);
      chk("vec_active", active, 1);
      drain("vec_drain", 80);
    end

    // All four continuously valid: rotation and inter-frame gap.
    cfg_par_en  = 4'b0101;
    cfg_par_typ = 4'b0011;
    for (int i = 0; i < N; i++) req_data[8*i +: 8] = 8'(8'h10 * i + 1);
    grants.delete();
    fall_cyc = -1;
    gap_chk = 1'b1;
    cont = 1'b1;
    req_valid = '1;
    cnt = 0;
    while (grants.size() < 6 && cnt < 400) begin
      cyc();
      cnt++;
    end
    if (grants.size() < 6) tmo("rr_grants", 400);
    req_valid = '0;
    cont = 1'b0;
    gap_chk = 1'b0;
    for (int k = 0; k < 6 && k < grants.size(); k++)
      chk("rr_order", grants[k], k % 4);
    for (int w = 0; w + 3 < grants.size(); w++) begin
      seen = '0;
      for (int j = 0; j < 4; j++) seen[grants[w+j]] = 1'b1;
      chk("rr_window", seen, 4'hF);
    end
    drain("rr_drain", 120);

    // Busy already high at issue time.
    hold_busy = 1'b1;
    tx_busy = 1'b1;
    cyc();
    req_data[8*2 +: 8] = 8'h77;
    req_valid = 4'b0100;
    wait_acc("hold_accept", 20, id);
    cnt = 0;
    repeat (6) begin
      cyc();
      cnt += int'(strobe);
    end
    chk("hold_no_strobe", cnt, 0);
    hold_busy = 1'b0;
    tx_busy = (bcnt != 0);
    cyc();
    chk("strobe_at_release", strobe, 1);
    cnt = int'(strobe);
    repeat (8) begin
      cyc();
      cnt += int'(strobe);
    end
    chk("single_strobe", cnt, 1);
    drain("hold_drain", 80);

    // Busy never rises: re-issue after the timeout.
    no_busy = 1'b1;
    req_data[8*3 +: 8] = 8'h3C;
    req_valid = 4'b1000;
    wait_acc("to_accept", 20, id);
    cyc();
    chk("to_first_strobe", strobe, 1);
    chk("to_err_at_issue", terr_s, 0);
    t0 = cyc_n;
    repeat (3) begin
      cyc();
      chk("to_quiet", strobe, 0);
    end
    chk("to_err_before", terr_s, 0);
    cyc();
    chk("to_reissue", strobe, 1);
    chk("to_reissue_gap", cyc_n - t0, 4);
    chk("to_err_set", terr_s, 1);
    no_busy = 1'b0;
    drain("to_drain", 120);
    chk("to_err_sticky", timeout_err, 1);

    // Reset during WAIT_DONE, then priority restarts at requester 0.
    req_data[8*2 +: 8] = 8'h6B;
    req_valid = 4'b0100;
    wait_acc("rst_accept", 20, id);
    cnt = 0;
    while (!prev_busy && cnt < 20) begin
      cyc();
      cnt++;
    end
    if (!prev_busy) tmo("rst_busy_rise", 20);
    chk("rst_pre_active", active, 1);
    req_valid = 4'b1101;
    #2;
    RST_n = 1'b0;
    #1;
    chk_reset("async_rst");
    rst_model();
    cyc();
    cyc();
    chk_reset("rst_hold");
    RST_n = 1'b1;
    wait_acc("post_rst_accept", 20, id);
    chk("first_after_rst", id, 0);
    drain("post_rst_drain", 300);
    chk("post_rst_grants", grants.size(), 3);
    if (grants.size() == 3) begin
      chk("post_rst_g1", grants[1], 2);
      chk("post_rst_g2", grants[2], 3);
    end
    chk("sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

Shares a single UART transmitter among `NUM_REQ` byte-stream requesters with round-robin arbitration. It also applies each requester's parity configuration to the transmitter and sequences the transmitter's `DATA_VALID`/`Busy` handshake. It sits between the host-side byte producers and the `P_DATA`/`PAR_EN`/`PAR_TYP`/`DATA_VALID` inputs of the UART transmitter, and enforces an optional inter-frame gap.

## Interface
Parameters:
- `NUM_REQ`, default 4: number of requesters, 2..16.
- `GAP_CYCLES`, default 0: idle CLK cycles inserted after each frame completes.
- `BUSY_TIMEOUT`, default 4: cycles to wait for `tx_busy` to rise after an issue.

Ports:
- `CLK` in 1: clock.
- `RST_n` in 1: reset, asynchronous, active-low.
- `req_valid` in NUM_REQ: requester i has a byte pending; its data must be held stable until accepted.
- `req_data` in 8*NUM_REQ: byte of requester i at bits [8i+7:8i].
- `cfg_par_en` in NUM_REQ: per-requester parity enable.
- `cfg_par_typ` in NUM_REQ: per-requester parity type.
- `req_ready` out NUM_REQ: one-cycle accept pulse, one-hot; accept = `req_valid[i] & req_ready[i]`.
- `tx_busy` in 1: transmitter Busy.
- `tx_p_data` out 8: byte to transmitter.
- `tx_par_en` out 1: parity enable for the current frame.
- `tx_par_typ` out 1: parity type for the current frame.
- `tx_data_valid` out 1: single-cycle issue strobe.
- `grant_id` out clog2(NUM_REQ): requester owning the current frame.
- `active` out 1: high from accept until the frame (and gap) completes.
- `timeout_err` out 1: sticky; set when a re-issue occurs, cleared only by reset.

## Operation
- States: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP.
- **IDLE:**
  - If any `req_valid`, grant the first requester at or after `rr_ptr`, searching upward with wrap.
  - Pulse that requester's `req_ready`.
  - Latch `req_data`, `cfg_par_en` and `cfg_par_typ` into `tx_p_data`/`tx_par_en`/`tx_par_typ`; set `grant_id`.
  - Set `rr_ptr` to grant+1, wrapping NUM_REQ-1 to 0.
  - Go to ISSUE.
- **ISSUE:** if `tx_busy`=0, assert `tx_data_valid` for one cycle and go to WAIT_BUSY; otherwise stay, with `tx_data_valid` low.
- **WAIT_BUSY:**
  - `tx_busy`=1 goes to WAIT_DONE.
  - After BUSY_TIMEOUT cycles with `tx_busy` still low: set `timeout_err` and return to ISSUE to re-issue the same byte.
- **WAIT_DONE:** on `tx_busy` 1→0, go to GAP if GAP_CYCLES>0, else IDLE.
- **GAP:** count GAP_CYCLES cycles, then go to IDLE.
- Latched `tx_*` outputs hold their values from accept until the next accept.
- A requester that drops `req_valid` before being granted is simply skipped; it has no claim on a later grant.
- `req_valid` changes during a frame do not affect the frame in progress.

## Timing
- Reset values:
  - `req_ready`, `tx_data_valid`, `active`, `timeout_err`: 0.
  - `tx_p_data`: 8'h00. `tx_par_en`, `tx_par_typ`: 0.
  - `grant_id`, `rr_ptr`: 0, so requester 0 has first priority.
- Accept in cycle N (IDLE). Earliest `tx_data_valid` is cycle N+1.
- `active` is high from N+1 until the cycle the FSM re-enters IDLE.
- Back-to-back throughput: the next accept occurs one cycle after the `tx_busy` fall (GAP_CYCLES=0), or GAP_CYCLES+1 cycles after it.
- All requesters valid: grants rotate 0,1,2,3,0,… Each requester is granted at most once per NUM_REQ frames.
- RST_n asserted mid-frame: the FSM returns to IDLE immediately and asynchronously, and every output takes its reset value. The transmitter shares RST_n, so no half-frame is resumed.
- `tx_data_valid` is never high while `tx_busy`=1, and is never high for two consecutive cycles.

## Configuration
- **`UART_TX_SCHED_HDR_EN` defined:** every grant sends two frames.
  - First frame is a header byte: {4'hA, grant_id zero-extended to 4 bits}, using the granted requester's parity settings.
  - Second frame is the data byte.
  - A HDR flag selects header vs data through ISSUE/WAIT_BUSY/WAIT_DONE.
  - GAP is applied after each of the two frames.
- **Undefined:** one frame per grant; no header logic is compiled.

## Structure
- `uart_tx_sched_pkg` holds:
  - the state enum;
  - `HDR_TAG` = 4'hA;
  - a `clog2` helper function.
- One sub-module, `rr_arbiter`: NUM_REQ-wide request vector plus pointer in, one-hot grant and encoded id out. It is purely combinational; the pointer register lives in the parent.

## Test plan
- **Single requester:** req_valid=4'b0010, data 8'h5A, cfg_par_en[1]=1, cfg_par_typ[1]=0.
  - `req_ready`=4'b0010 for one cycle; `tx_p_data`=8'h5A, `tx_par_en`=1, `tx_par_typ`=0.
  - `tx_data_valid` one cycle later; `grant_id`=1.
- **All four valid continuously:** grant order is 0,1,2,3,0,1; no requester is granted twice in any window of 4 grants.
- **Transmitter model holds tx_busy=1 at issue time:** `tx_data_valid` stays low until `tx_busy` falls, then pulses exactly once.
- **tx_busy never rises, BUSY_TIMEOUT=4:** re-issue occurs 4 cycles after the first strobe; `timeout_err`=1 and stays 1.
- **GAP_CYCLES=3, back-to-back requests:** exactly 3 idle cycles between the `tx_busy` fall and the next `req_ready`.
- **RST_n pulsed low during WAIT_DONE:** all outputs return to reset values at once; after release, the first grant goes to requester 0. With `UART_TX_SCHED_HDR_EN` defined, requester 2 produces frames 8'hA2 then its data byte.
